sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_if.sv | 48 ++++
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, data port, SRAM macro pins and error signals
// seen by sram_arbiter; the arbiter uses the slave view.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [BE_WIDTH-1:0]   d_be;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  sram_csb;
    logic                  sram_web;
    logic                  sram_spare_wen;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH:0]   sram_din;
    logic [DATA_WIDTH:0]   sram_dout;

    logic                  parity_err;
    logic                  err_sticky;
    logic                  err_clr;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_dout, err_clr,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               sram_csb, sram_web, sram_spare_wen, sram_addr, sram_din,
               parity_err, err_sticky
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_dout, err_clr,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               sram_csb, sram_web, sram_spare_wen, sram_addr, sram_din,
               parity_err, err_sticky
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between fetch and data
// ports, with read-modify-write for partial stores and even parity in bit 32.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    sram_arbiter_if.slave   bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_rr_fetch;      // 1: fetch wins the next tie
    logic                  w_rr_fetch_next;
    logic                  r_i_rvalid;
    logic                  r_d_rvalid;
    logic                  r_err_sticky;

    logic                  w_fetch_sel;
    logic                  w_data_sel;
    logic                  w_i_rd;
    logic                  w_d_rd;
    logic                  w_i_gnt;
    logic                  w_d_gnt;
    logic                  w_csb;
    logic                  w_web;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH:0]   w_din;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_check;
    logic                  w_parity_err;

    always_comb begin
        w_merged = '0;
        for (int b = 0; b < BE_WIDTH; b++) begin
            w_merged[8*b +: 8] = bus.d_be[b] ? bus.d_wdata[8*b +: 8] : bus.sram_dout[8*b +: 8];
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_next    = r_state;
        w_rr_fetch_next = r_rr_fetch;
        w_fetch_sel     = 1'b0;
        w_data_sel      = 1'b0;
        w_i_rd          = 1'b0;
        w_d_rd          = 1'b0;
        w_i_gnt         = 1'b0;
        w_d_gnt         = 1'b0;
        w_csb           = 1'b1;
        w_web           = 1'b1;
        w_addr          = '0;
        w_din           = '0;
        // Commands are combinational, so they are held off while reset is high.
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    w_fetch_sel = bus.i_req && (!bus.d_req || r_rr_fetch);
                    w_data_sel  = bus.d_req && !w_fetch_sel;
                    if (w_fetch_sel) begin
                        w_csb           = 1'b0;
                        w_addr          = bus.i_addr;
                        w_i_gnt         = 1'b1;
                        w_i_rd          = 1'b1;
                        w_rr_fetch_next = 1'b0;
                    end else if (w_data_sel) begin
                        w_rr_fetch_next = 1'b1;
                        if (!bus.d_we) begin
                            w_csb   = 1'b0;
                            w_addr  = bus.d_addr;
                            w_d_gnt = 1'b1;
                            w_d_rd  = 1'b1;
                        end else if (&bus.d_be) begin
                            w_csb   = 1'b0;
                            w_web   = 1'b0;
                            w_addr  = bus.d_addr;
                            w_din   = {^bus.d_wdata, bus.d_wdata};
                            w_d_gnt = 1'b1;
                        end else if (bus.d_be == '0) begin
                            w_d_gnt = 1'b1;
                        end else begin
                            w_csb        = 1'b0;
                            w_addr       = bus.d_addr;
                            w_state_next = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    w_csb        = 1'b0;
                    w_web        = 1'b0;
                    w_addr       = bus.d_addr;
                    w_din        = {^w_merged, w_merged};
                    w_d_gnt      = 1'b1;
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign w_check      = r_i_rvalid || r_d_rvalid || (r_state == RMW_WR);
    assign w_parity_err = w_check && (^bus.sram_dout);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr_fetch   <= 1'b1;
            r_i_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            r_state    <= w_state_next;
            r_rr_fetch <= w_rr_fetch_next;
            r_i_rvalid <= w_i_rd;
            r_d_rvalid <= w_d_rd;
            if (w_parity_err) begin
                r_err_sticky <= 1'b1;
            end else if (bus.err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    assign bus.i_gnt          = w_i_gnt;
    assign bus.d_gnt          = w_d_gnt;
    assign bus.i_rvalid       = r_i_rvalid;
    assign bus.d_rvalid       = r_d_rvalid;
    assign bus.i_rdata        = r_i_rvalid ? bus.sram_dout[DATA_WIDTH-1:0] : '0;
    assign bus.d_rdata        = r_d_rvalid ? bus.sram_dout[DATA_WIDTH-1:0] : '0;
    assign bus.sram_csb       = w_csb;
    assign bus.sram_web       = w_web;
    assign bus.sram_spare_wen = !w_csb && !w_web;
    assign bus.sram_addr      = w_addr;
    assign bus.sram_din       = w_din;
    assign bus.parity_err     = w_parity_err;
    assign bus.err_sticky     = r_err_sticky;
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// two-port traffic checked against a word-level memory model.
module tb_sram_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Macro model: one-cycle read latency; corrupt flips the returned parity bit.
    logic [DW:0]   macro_mem [1024];
    logic [DW:0]   dout_q = '0;
    logic          corrupt = 1'b0;
    logic [DW-1:0] ref_mem [1024];

    always @(posedge clk) begin
        if (!bus.sram_csb) begin
            if (!bus.sram_web) macro_mem[bus.sram_addr] <= bus.sram_din;
            else               dout_q <= macro_mem[bus.sram_addr];
        end
    end
    assign bus.sram_dout = dout_q ^ {corrupt, {DW{1'b0}}};

    // {i_gnt, d_gnt, i_rvalid, d_rvalid, csb, web, spare_wen, parity_err, err_sticky}
    logic [8:0] w_stat;
    assign w_stat = {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.sram_csb,
                     bus.sram_web, bus.sram_spare_wen, bus.parity_err, bus.err_sticky};

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [3:0] be);
        logic [DW-1:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.err_clr = 1'b0;
    endtask

    task automatic drive_data(input logic we, input logic [3:0] be, input int addr,
                              input logic [DW-1:0] wdata);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be;
        bus.d_addr = AW'(addr); bus.d_wdata = wdata;
    endtask

    task automatic test_reset();
        bus_idle();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.sram_addr, bus.sram_din} !== {9'b000011000, {AW{1'b0}}, {(DW+1){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_values: got stat=%b addr=%h din=%h want stat=000011000 addr=0 din=0",
                     w_stat, bus.sram_addr, bus.sram_din);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.i_rdata, bus.d_rdata} !== {9'b000011000, {(2*DW){1'b0}}}) begin
            n_fail++;
            $display("FAIL idle_after_reset: got stat=%b want 000011000", w_stat);
        end
        next_cycle();
    endtask

    task automatic init_words();
        logic [DW-1:0] v;
        for (int a = 0; a < 16; a++) begin
            v = (a == 5) ? 32'h0 : $urandom;
            drive_data(1'b1, 4'hF, a, v);
            @(negedge clk);
            n_tests++;
            if ({bus.d_gnt, bus.sram_web, bus.sram_din} !== {1'b1, 1'b0, ^v, v}) begin
                n_fail++;
                $display("FAIL init_write[%0d]: got gnt=%b web=%b din=%h want gnt=1 web=0 din=%h",
                         a, bus.d_gnt, bus.sram_web, bus.sram_din, {^v, v});
            end
            ref_mem[a] = v;
            next_cycle();
        end
        bus_idle();
    endtask

    task automatic test_write_fetch();
        logic [DW-1:0] v = 32'hDEADBEEF;
        drive_data(1'b1, 4'hF, 5, v);
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.sram_addr, bus.sram_din} !== {9'b010000100, AW'(5), ^v, v}) begin
            n_fail++;
            $display("FAIL full_write: got stat=%b addr=%h din=%h want stat=010000100 addr=5 din=%h",
                     w_stat, bus.sram_addr, bus.sram_din, {^v, v});
        end
        ref_mem[5] = v;
        next_cycle();
        bus_idle();
        bus.i_req = 1'b1; bus.i_addr = AW'(5);
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.sram_addr} !== {9'b100001000, AW'(5)}) begin
            n_fail++;
            $display("FAIL fetch_grant: got stat=%b addr=%h want stat=100001000 addr=5", w_stat, bus.sram_addr);
        end
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.i_rdata} !== {9'b001011000, ref_mem[5]}) begin
            n_fail++;
            $display("FAIL fetch_readback: got stat=%b rdata=%h want stat=001011000 rdata=%h",
                     w_stat, bus.i_rdata, ref_mem[5]);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic exp_fetch;
        logic prev_fetch;
        drive_data(1'b0, 4'h0, 2, '0);
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b010001000) begin
            n_fail++;
            $display("FAIL rr_prime: got stat=%b want 010001000", w_stat);
        end
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = AW'(1);
        for (int k = 0; k < 8; k++) begin
            exp_fetch  = (k % 2 == 0);
            prev_fetch = (k == 0) ? 1'b0 : ((k - 1) % 2 == 0);
            @(negedge clk);
            n_tests++;
            if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.sram_addr} !==
                {exp_fetch, !exp_fetch, prev_fetch, !prev_fetch, AW'(exp_fetch ? 1 : 2)} ||
                (prev_fetch ? bus.i_rdata : bus.d_rdata) !== ref_mem[prev_fetch ? 1 : 2]) begin
                n_fail++;
                $display("FAIL rr_cycle[%0d]: got gnt=%b%b rvalid=%b%b addr=%h i_rdata=%h d_rdata=%h want gnt=%b%b rvalid=%b%b",
                         k, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.sram_addr,
                         bus.i_rdata, bus.d_rdata, exp_fetch, !exp_fetch, prev_fetch, !prev_fetch);
            end
            next_cycle();
        end
        bus_idle();
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.d_rdata} !== {9'b000111000, ref_mem[2]}) begin
            n_fail++;
            $display("FAIL rr_last_rvalid: got stat=%b d_rdata=%h want stat=000111000 d_rdata=%h",
                     w_stat, bus.d_rdata, ref_mem[2]);
        end
        next_cycle();
    endtask

    task automatic test_partial_write();
        logic [DW-1:0] m = merge_bytes(ref_mem[5], 32'h0000AB00, 4'b0010);
        drive_data(1'b1, 4'b0010, 5, 32'h0000AB00);
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.sram_addr} !== {9'b000001000, AW'(5)}) begin
            n_fail++;
            $display("FAIL rmw_read: got stat=%b addr=%h want stat=000001000 addr=5", w_stat, bus.sram_addr);
        end
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = AW'(5);
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.sram_addr, bus.sram_din} !== {9'b010000100, AW'(5), ^m, m}) begin
            n_fail++;
            $display("FAIL rmw_write: got stat=%b addr=%h din=%h want stat=010000100 addr=5 din=%h",
                     w_stat, bus.sram_addr, bus.sram_din, {^m, m});
        end
        ref_mem[5] = m;
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b100001000) begin
            n_fail++;
            $display("FAIL rmw_fetch_after: got stat=%b want 100001000", w_stat);
        end
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.i_rdata} !== {9'b001011000, ref_mem[5]}) begin
            n_fail++;
            $display("FAIL rmw_readback: got stat=%b rdata=%h want stat=001011000 rdata=%h",
                     w_stat, bus.i_rdata, ref_mem[5]);
        end
        next_cycle();
    endtask

    task automatic test_parity();
        logic [DW-1:0] w = $urandom;
        logic [DW-1:0] m = merge_bytes(ref_mem[6], w, 4'b0001);
        bus.i_req = 1'b1; bus.i_addr = AW'(3);
        @(negedge clk);
        next_cycle();
        bus.i_req = 1'b0; corrupt = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.i_rdata} !== {9'b001011010, ref_mem[3]}) begin
            n_fail++;
            $display("FAIL parity_pulse: got stat=%b rdata=%h want stat=001011010 rdata=%h",
                     w_stat, bus.i_rdata, ref_mem[3]);
        end
        next_cycle();
        corrupt = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b000011001) begin
            n_fail++;
            $display("FAIL sticky_set: got stat=%b want 000011001", w_stat);
        end
        next_cycle();
        bus.err_clr = 1'b1;
        next_cycle();
        bus.err_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b000011000) begin
            n_fail++;
            $display("FAIL sticky_clear: got stat=%b want 000011000", w_stat);
        end
        next_cycle();
        drive_data(1'b0, 4'h0, 4, '0);
        next_cycle();
        bus.d_req = 1'b0; corrupt = 1'b1; bus.err_clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b000111010) begin
            n_fail++;
            $display("FAIL parity_data_port: got stat=%b want 000111010", w_stat);
        end
        next_cycle();
        corrupt = 1'b0; bus.err_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b000011001) begin
            n_fail++;
            $display("FAIL set_beats_clear: got stat=%b want 000011001", w_stat);
        end
        next_cycle();
        bus.err_clr = 1'b1;
        next_cycle();
        bus.err_clr = 1'b0;
        drive_data(1'b1, 4'b0001, 6, w);
        next_cycle();
        corrupt = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({w_stat, bus.sram_din} !== {9'b010000110, ^m, m}) begin
            n_fail++;
            $display("FAIL rmw_parity: got stat=%b din=%h want stat=010000110 din=%h",
                     w_stat, bus.sram_din, {^m, m});
        end
        ref_mem[6] = m;
        next_cycle();
        corrupt = 1'b0; bus.d_req = 1'b0;
        next_cycle();
        bus.err_clr = 1'b1;
        next_cycle();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_rmw();
        logic [DW-1:0] old = ref_mem[9];
        drive_data(1'b1, 4'b1100, 9, ~old);
        @(negedge clk);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b000011000) begin
            n_fail++;
            $display("FAIL reset_mid_rmw: got stat=%b want 000011000", w_stat);
        end
        next_cycle();
        reset = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_stat !== 9'b000011000) begin
            n_fail++;
            $display("FAIL after_reset_rmw: got stat=%b want 000011000", w_stat);
        end
        next_cycle();
        bus.i_req = 1'b1; bus.i_addr = AW'(9);
        next_cycle();
        bus.i_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.i_rvalid, bus.i_rdata} !== {1'b1, old}) begin
            n_fail++;
            $display("FAIL rmw_abort_readback: got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                     bus.i_rvalid, bus.i_rdata, old);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic i_pend = 1'b0;
        logic d_pend = 1'b0;
        logic [AW-1:0] ia = '0;
        logic [AW-1:0] da = '0;
        logic dwe = 1'b0;
        logic [3:0] dbe = '0;
        logic [DW-1:0] dwd = '0;
        logic exp_v = 1'b0;
        logic exp_fetch = 1'b0;
        logic [DW-1:0] exp_data = '0;
        logic [DW-1:0] m;
        int i_wait = 0;
        int d_wait = 0;
        for (int c = 0; c <= 400; c++) begin
            if (c == 400) begin
                i_pend = 1'b0; d_pend = 1'b0;
            end else begin
                if (!i_pend && $urandom_range(0, 99) < 60) begin
                    i_pend = 1'b1; ia = AW'($urandom_range(0, 15));
                end
                if (!d_pend && $urandom_range(0, 99) < 60) begin
                    d_pend = 1'b1; da = AW'($urandom_range(0, 15)); dwe = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0:       dbe = 4'h0;
                        1:       dbe = 4'hF;
                        default: dbe = 4'($urandom);
                    endcase
                    dwd = $urandom;
                end
            end
            bus.i_req = i_pend; bus.i_addr = ia;
            bus.d_req = d_pend; bus.d_we = dwe; bus.d_be = dbe; bus.d_addr = da; bus.d_wdata = dwd;
            @(negedge clk);
            n_tests++;
            if ({bus.i_rvalid, bus.d_rvalid, bus.parity_err} !== {exp_v && exp_fetch, exp_v && !exp_fetch, 1'b0} ||
                (exp_v && (exp_fetch ? bus.i_rdata : bus.d_rdata) !== exp_data)) begin
                n_fail++;
                $display("FAIL rand_read[%0d]: got rvalid=%b%b perr=%b i_rdata=%h d_rdata=%h want rvalid=%b%b data=%h",
                         c, bus.i_rvalid, bus.d_rvalid, bus.parity_err, bus.i_rdata, bus.d_rdata,
                         exp_v && exp_fetch, exp_v && !exp_fetch, exp_data);
            end
            exp_v = 1'b0;
            n_tests++;
            if ((bus.i_gnt && (bus.d_gnt || !i_pend)) || (bus.d_gnt && !d_pend) || i_wait > 3 || d_wait > 3) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got gnt=%b%b pend=%b%b wait=%0d/%0d want legal grant within 3 cycles",
                         c, bus.i_gnt, bus.d_gnt, i_pend, d_pend, i_wait, d_wait);
                i_wait = 0; d_wait = 0;
            end
            if (bus.i_gnt) begin
                exp_v = 1'b1; exp_fetch = 1'b1; exp_data = ref_mem[ia];
                i_pend = 1'b0; i_wait = 0;
            end else if (i_pend) begin
                i_wait++;
            end
            if (bus.d_gnt) begin
                if (!dwe) begin
                    exp_v = 1'b1; exp_fetch = 1'b0; exp_data = ref_mem[da];
                end else begin
                    m = merge_bytes(ref_mem[da], dwd, dbe);
                    n_tests++;
                    if ((dbe == 4'h0 && bus.sram_csb !== 1'b1) ||
                        (dbe != 4'h0 && {bus.sram_csb, bus.sram_web, bus.sram_addr, bus.sram_din} !== {2'b00, da, ^m, m})) begin
                        n_fail++;
                        $display("FAIL rand_write[%0d]: got csb=%b web=%b addr=%h din=%h want be=%b addr=%h din=%h",
                                 c, bus.sram_csb, bus.sram_web, bus.sram_addr, bus.sram_din, dbe, da, {^m, m});
                    end
                    ref_mem[da] = m;
                end
                d_pend = 1'b0; d_wait = 0;
            end else if (d_pend) begin
                d_wait++;
            end
            next_cycle();
        end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        test_reset();
        init_words();
        test_write_fetch();
        test_round_robin();
        test_partial_write();
        test_parity();
        test_reset_mid_rmw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 ns want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
